// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host transmitter and its companions.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam logic [1:0] ST_ACK     = 2'b00;
    localparam logic [1:0] ST_NACK    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser with falling-edge detect for one raw PS/2 line.
module ps2_line_sync
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_sync,
    output logic line_fall
);

    logic meta;
    logic prev;

    // Idle PS/2 lines are high, so reset to 1 to avoid a spurious fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta      <= 1'b1;
            line_sync <= 1'b1;
            prev      <= 1'b1;
        end else begin
            meta      <= line_in;
            line_sync <= meta;
            prev      <= line_sync;
        end
    end

    assign line_fall = prev & ~line_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte over open-drain
// clock/data lines and reports ACK, NACK or timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic [1:0] status,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [8:0]    shift_q;
    logic [3:0]    bit_idx;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic [1:0]    rec_status;
    logic          clk_sync;
    logic          clk_fall;
    logic          data_sync;
    logic          data_fall_unused;
    logic          timing;

    ps2_line_sync u_clk_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_in   (ps2_clk_in),
        .line_sync (clk_sync),
        .line_fall (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_in   (ps2_data_in),
        .line_sync (data_sync),
        .line_fall (data_fall_unused)
    );

    assign timing = (state == REQ) || (state == SHIFT) ||
                    (state == ACK) || (state == WAIT_IDLE);

    // shift_q holds {parity, data}; shifting in ones makes the 10th fall release the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            shift_q            <= '1;
            bit_idx            <= '0;
            inh_cnt            <= '0;
            to_cnt             <= '0;
            rec_status         <= ST_ACK;
            tx_ready           <= 1'b1;
            busy               <= 1'b0;
            done               <= 1'b0;
            status             <= ST_ACK;
            ps2_clk_drive_low  <= 1'b0;
            ps2_data_drive_low <= 1'b0;
        end else begin
            done <= 1'b0;
            if (timing) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end

            if (timing && to_cnt == TO_LAST) begin
                state              <= IDLE;
                tx_ready           <= 1'b1;
                busy               <= 1'b0;
                done               <= 1'b1;
                status             <= ST_TIMEOUT;
                ps2_clk_drive_low  <= 1'b0;
                ps2_data_drive_low <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_valid && tx_ready && !done) begin
                            shift_q           <= {odd_parity(tx_data), tx_data};
                            inh_cnt           <= '0;
                            bit_idx           <= '0;
                            tx_ready          <= 1'b0;
                            busy              <= 1'b1;
                            ps2_clk_drive_low <= 1'b1;
                            state             <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        inh_cnt <= inh_cnt + 1'b1;
                        if (inh_cnt == INH_PRE) begin
                            ps2_data_drive_low <= 1'b1;
                        end
                        if (inh_cnt == INH_LAST) begin
                            ps2_clk_drive_low <= 1'b0;
                            state             <= REQ;
                        end
                    end
                    REQ, SHIFT: begin
                        if (clk_fall) begin
                            ps2_data_drive_low <= ~shift_q[0];
                            shift_q            <= {1'b1, shift_q[8:1]};
                            bit_idx            <= bit_idx + 1'b1;
                            state              <= (bit_idx == 4'd9) ? ACK : SHIFT;
                        end
                    end
                    ACK: begin
                        if (clk_fall) begin
                            rec_status <= data_sync ? ST_NACK : ST_ACK;
                            state      <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        if (clk_sync && data_sync) begin
                            done     <= 1'b1;
                            status   <= rec_status;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic [1:0] status;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_drive_low;
    logic       ps2_data_drive_low;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Open-drain wired-AND of host and device drivers.
    assign ps2_clk_in  = ~(ps2_clk_drive_low | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_drive_low | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .busy               (busy),
        .done               (done),
        .status             (status),
        .ps2_clk_in         (ps2_clk_in),
        .ps2_data_in        (ps2_data_in),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Bits the device should see on rising edges 1..10: data LSB first, odd parity, stop.
    function automatic logic [9:0] expected_frame(input logic [7:0] b);
        logic [9:0] f;
        f[7:0] = b;
        f[8]   = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        f[9]   = 1'b1;
        return f;
    endfunction

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Plays the keyboard side of one transfer; returns in the cycle done is seen.
    task automatic deviceTransfer(input logic [7:0] b, input logic ack_low, input string tag);
        int n;
        int inh;
        int both;
        logic [9:0] sampled;
        sampled = '0;
        n = 0;
        while (!ps2_clk_drive_low && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " inhibit_start"}, ps2_clk_drive_low, 1);
        inh  = 0;
        both = 0;
        while (ps2_clk_drive_low && inh < 100) begin
            inh++;
            if (ps2_data_drive_low) both++;
            @(negedge clk);
        end
        checkOutput({tag, " inhibit_len"}, inh, INH);
        checkOutput({tag, " start_overlap"}, both, 1);
        checkOutput({tag, " start_bit"}, ps2_data_drive_low, 1);
        repeat (20) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) sampled[k-1] = ps2_data_in;
            if (k == 10) dev_data_low = ack_low;
            if (k == 11) dev_data_low = 1'b0;
            else repeat (20) @(negedge clk);
        end
        checkOutput({tag, " frame"}, sampled, expected_frame(b));
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " done"}, done, 1);
        checkOutput({tag, " status"}, status, ack_low ? 2'b00 : 2'b01);
        checkOutput({tag, " ready_at_done"}, tx_ready, 1);
        checkOutput({tag, " lines_at_done"}, {ps2_clk_drive_low, ps2_data_drive_low}, 0);
    endtask

    initial begin
        int n;
        int bad;
        logic [7:0] rb;
        logic [1:0] last_status;

        $display("[TB] start");
        repeat (3) @(negedge clk);
        checkOutput("rst tx_ready", tx_ready, 1);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst done", done, 0);
        checkOutput("rst status", status, 0);
        checkOutput("rst lines", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xED with ACK
        applyStimulus(8'hED);
        deviceTransfer(8'hED, 1'b1, "ed_ack");
        @(negedge clk);
        checkOutput("ed_ack done_pulse", done, 0);
        checkOutput("ed_ack idle_busy", busy, 0);
        checkOutput("ed_ack idle_lines", {ps2_clk_drive_low, ps2_data_drive_low}, 0);

        // 0x00 with NACK; status must hold after the pulse
        applyStimulus(8'h00);
        deviceTransfer(8'h00, 1'b0, "00_nack");
        repeat (10) @(negedge clk);
        checkOutput("00_nack status_held", status, 2'b01);

        // 0xFF, device never clocks
        applyStimulus(8'hFF);
        n = 0;
        while (ps2_clk_drive_low && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tmo cycles", n, TMO);
        checkOutput("tmo done", done, 1);
        checkOutput("tmo status", status, 2'b10);
        checkOutput("tmo lines", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        checkOutput("tmo ready", tx_ready, 1);
        repeat (5) @(negedge clk);

        // 0xF4, reset after the 4th falling edge
        rb = 8'hF4;
        applyStimulus(rb);
        n = 0;
        while (ps2_clk_drive_low && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            dev_clk_low = 1'b1;
            if (k < 4) begin
                repeat (20) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (20) @(negedge clk);
            end
        end
        repeat (10) @(negedge clk);
        checkOutput("rstmid data_before", ps2_data_drive_low, !rb[3]);
        #1 rst_n = 1'b0;
        #1 checkOutput("rstmid lines_async", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dev_clk_low = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) bad++;
        end
        checkOutput("rstmid no_done", bad, 0);
        checkOutput("rstmid ready", tx_ready, 1);

        // tx_valid held: 0xED then 0x55 accepted only after done
        @(negedge clk);
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h55;
        deviceTransfer(8'hED, 1'b1, "b2b_first");
        @(negedge clk);
        checkOutput("b2b not_in_done_cycle", busy, 0);
        @(negedge clk);
        checkOutput("b2b accept_after_done", busy, 1);
        tx_valid = 1'b0;
        deviceTransfer(8'h55, 1'b1, "b2b_second");
        @(negedge clk);

        // Randomised bytes and device responses
        for (int i = 0; i < 4; i++) begin
            logic [7:0] rbyte;
            logic       rack;
            rbyte = 8'($urandom_range(0, 255));
            rack  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 8)) @(negedge clk);
            applyStimulus(rbyte);
            deviceTransfer(rbyte, rack, $sformatf("rand%0d_%02h", i, rbyte));
            @(negedge clk);
        end

        // Idle line
        bad = 0;
        repeat (10000) begin
            @(negedge clk);
            if (busy || ps2_clk_drive_low || ps2_data_drive_low) bad++;
        end
        checkOutput("idle quiet", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
